// File: rtl/rs_int_station.sv
`default_nettype none
// ============================================================================
// Module   : rs_int_station
// Purpose  : Integer reservation station. Buffers dispatched integer ops in
//            an age-ordered compacting queue (entry 0 oldest). Waiting source
//            operands are captured from the common data bus (CDB). The oldest
//            op with both operands ready is offered to the integer ALU.
//            signal_miss flushes every entry.
// Ports    :
//   clk, rst_n                      clock (rising edge), async active-low reset
//   rs_int_we, disp_*               dispatch write request and op fields
//   rs_int_is_full                  no free entry (register-decoded)
//   cdb_valid, cdb_tag, cdb_data    result broadcast for operand wakeup
//   issue_valid, issue_ready        issue handshake with the ALU
//   issue_op/dest/s1/s2             selected op (zero when nothing to issue)
//   signal_miss                     flush all entries
// Revision : 1.0 - initial release
// ============================================================================
module rs_int_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rs_int_we,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [TAG_W-1:0]  disp_dest,
    input  logic              disp_s1_rdy,
    input  logic [TAG_W-1:0]  disp_s1_tag,
    input  logic [DATA_W-1:0] disp_s1_val,
    input  logic              disp_s2_rdy,
    input  logic [TAG_W-1:0]  disp_s2_tag,
    input  logic [DATA_W-1:0] disp_s2_val,
    output logic              rs_int_is_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic [TAG_W-1:0]  issue_dest,
    output logic [DATA_W-1:0] issue_s1,
    output logic [DATA_W-1:0] issue_s2,
    input  logic              signal_miss
);

    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_SW = $clog2(DEPTH);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_val;
    } entry_t;

    // Storage: entries [0, r_count) are valid, index 0 is the oldest.
    entry_t          r_ent [DEPTH];
    logic [c_CW-1:0] r_count;

    logic [DEPTH-1:0] w_rdy;
    logic             w_any;
    logic [c_SW-1:0]  w_sel;
    entry_t           w_sel_ent;
    entry_t           w_new;
    entry_t           w_wk  [DEPTH];
    entry_t           w_nxt [DEPTH];
    logic             w_full;
    logic             w_do_issue;
    logic             w_do_disp;
    logic [c_CW-1:0]  w_wr_idx;
    logic [c_SW-1:0]  w_wr_sel;
    logic [c_CW-1:0]  w_count_nxt;

    // Capture the CDB value into any still-waiting source with a matching tag.
    // Sources that are already ready are never overwritten.
    function automatic entry_t wake(input entry_t e, input logic cv,
                                    input logic [TAG_W-1:0] ct,
                                    input logic [DATA_W-1:0] cd);
        entry_t r;
        r = e;
        if (cv && !e.s1_rdy && (e.s1_tag == ct)) begin
            r.s1_rdy = 1'b1;
            r.s1_val = cd;
        end
        if (cv && !e.s2_rdy && (e.s2_tag == ct)) begin
            r.s2_rdy = 1'b1;
            r.s2_val = cd;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Select: oldest valid entry with both operands ready, registers only.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = (c_CW'(i) < r_count) && r_ent[i].s1_rdy && r_ent[i].s2_rdy;
        end
    end

    // Scan from the youngest slot down so the lowest index wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_any = 1'b1;
                w_sel = c_SW'(i);
            end
        end
    end

    assign w_sel_ent      = r_ent[w_sel];
    assign w_full         = (r_count == c_DEPTH);
    assign rs_int_is_full = w_full;
    assign issue_valid    = w_any;
    assign issue_op       = w_any ? w_sel_ent.op     : '0;
    assign issue_dest     = w_any ? w_sel_ent.dest   : '0;
    assign issue_s1       = w_any ? w_sel_ent.s1_val : '0;
    assign issue_s2       = w_any ? w_sel_ent.s2_val : '0;

    // ------------------------------------------------------------------------
    // Next-state: wakeup, compaction on issue, then dispatch write.
    // ------------------------------------------------------------------------
    assign w_do_issue  = w_any && issue_ready;
    // Fullness is taken from the pre-edge count, so a slot freed by this
    // cycle's issue is not reused by this cycle's dispatch.
    assign w_do_disp   = rs_int_we && !w_full;
    assign w_wr_idx    = r_count - c_CW'(w_do_issue);
    assign w_wr_sel    = w_wr_idx[c_SW-1:0];
    assign w_count_nxt = r_count + c_CW'(w_do_disp) - c_CW'(w_do_issue);

    // Incoming op, with the same-cycle CDB bypass for waiting sources.
    always_comb begin
        w_new = wake('{op:     disp_op,
                       dest:   disp_dest,
                       s1_rdy: disp_s1_rdy,
                       s1_tag: disp_s1_tag,
                       s1_val: disp_s1_val,
                       s2_rdy: disp_s2_rdy,
                       s2_tag: disp_s2_tag,
                       s2_val: disp_s2_val},
                     cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wk[i]  = wake(r_ent[i], cdb_valid, cdb_tag, cdb_data);
            w_nxt[i] = w_wk[i];
        end
        // Entries younger than the issued one move down a slot; they carry
        // this cycle's wakeup with them.
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_do_issue && (i >= int'(w_sel))) begin
                w_nxt[i] = w_wk[i + 1];
            end
        end
        if (w_do_disp) begin
            w_nxt[w_wr_sel] = w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (signal_miss) begin
            // Flush dominates dispatch, issue and wakeup; stale payloads are
            // harmless because validity is derived from the count.
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_nxt[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_int_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_int_station
// Purpose  : Self-checking bench for rs_int_station. A queue-based model
//            tracks the station contents; a compare process checks outputs
//            each cycle, and directed scenarios pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_int_station;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rs_int_we = 1'b0;
    logic [OP_W-1:0]   disp_op = '0;
    logic [TAG_W-1:0]  disp_dest = '0;
    logic              disp_s1_rdy = 1'b0;
    logic [TAG_W-1:0]  disp_s1_tag = '0;
    logic [DATA_W-1:0] disp_s1_val = '0;
    logic              disp_s2_rdy = 1'b0;
    logic [TAG_W-1:0]  disp_s2_tag = '0;
    logic [DATA_W-1:0] disp_s2_val = '0;
    logic              rs_int_is_full;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              issue_valid;
    logic              issue_ready = 1'b0;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_dest;
    logic [DATA_W-1:0] issue_s1;
    logic [DATA_W-1:0] issue_s2;
    logic              signal_miss = 1'b0;

    always #5 clk = ~clk;

    rs_int_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .rs_int_we(rs_int_we),
        .disp_op(disp_op), .disp_dest(disp_dest),
        .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag), .disp_s1_val(disp_s1_val),
        .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag), .disp_s2_val(disp_s2_val),
        .rs_int_is_full(rs_int_is_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_s1(issue_s1), .issue_s2(issue_s2),
        .signal_miss(signal_miss)
    );

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest;
        bit                r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        bit                r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Oldest entry with both sources ready, or -1.
    function automatic int model_sel();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].r1 && q[i].r2) return i;
        end
        return -1;
    endfunction

    function automatic ent_t model_wake(input ent_t e);
        ent_t r = e;
        if (cdb_valid && !r.r1 && r.t1 == cdb_tag) begin r.r1 = 1'b1; r.v1 = cdb_data; end
        if (cdb_valid && !r.r2 && r.t2 == cdb_tag) begin r.r2 = 1'b1; r.v2 = cdb_data; end
        return r;
    endfunction

    // Model update at each edge, from pre-edge contents and current inputs.
    always @(posedge clk or negedge rst_n) begin
        int   s;
        bit   full;
        ent_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            s    = model_sel();
            full = (q.size() == DEPTH);
            if (signal_miss) begin
                q.delete();
            end else begin
                if (s >= 0 && issue_ready) q.delete(s);
                foreach (q[i]) q[i] = model_wake(q[i]);
                if (rs_int_we && !full) begin
                    e.op = disp_op;     e.dest = disp_dest;
                    e.r1 = disp_s1_rdy; e.t1 = disp_s1_tag; e.v1 = disp_s1_val;
                    e.r2 = disp_s2_rdy; e.t2 = disp_s2_tag; e.v2 = disp_s2_val;
                    q.push_back(model_wake(e));
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int s;
        if (rst_n) begin
            s = model_sel();
            chk("is_full", rs_int_is_full, q.size() == DEPTH);
            chk("issue_valid", issue_valid, s >= 0);
            if (s >= 0) begin
                chk("issue_op",   issue_op,   q[s].op);
                chk("issue_dest", issue_dest, q[s].dest);
                chk("issue_s1",   issue_s1,   q[s].v1);
                chk("issue_s2",   issue_s2,   q[s].v2);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        rs_int_we   = 1'b0;
        cdb_valid   = 1'b0;
        signal_miss = 1'b0;
    endtask

    task automatic disp(input int op, input int dest,
                        input bit r1, input int t1, input int v1,
                        input bit r2, input int t2, input int v2);
        rs_int_we   = 1'b1;
        disp_op     = OP_W'(op);
        disp_dest   = TAG_W'(dest);
        disp_s1_rdy = r1; disp_s1_tag = TAG_W'(t1); disp_s1_val = DATA_W'(v1);
        disp_s2_rdy = r2; disp_s2_tag = TAG_W'(t2); disp_s2_val = DATA_W'(v2);
    endtask

    task automatic cdb(input int tag, input int data);
        cdb_valid = 1'b1;
        cdb_tag   = TAG_W'(tag);
        cdb_data  = DATA_W'(data);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick();
        chk("rst_full",  rs_int_is_full, 0);
        chk("rst_valid", issue_valid, 0);
        chk("rst_op",    issue_op, 0);
        chk("rst_s1",    issue_s1, 0);
        rst_n = 1'b1;
        tick();

        // 1: both-ready op issues the cycle after dispatch.
        issue_ready = 1'b1;
        disp(1, 3, 1, 0, 5, 1, 0, 7); tick(); idle();
        chk("t1_valid", issue_valid, 1);
        chk("t1_s1",    issue_s1, 5);
        chk("t1_s2",    issue_s2, 7);
        chk("t1_dest",  issue_dest, 3);
        tick();
        chk("t1_empty", issue_valid, 0);

        // 2: waiting src1 woken by CDB, issuable the following cycle.
        issue_ready = 1'b0;
        disp(2, 4, 0, 9, 0, 1, 0, 3); tick(); idle();
        tick();
        chk("t2_wait", issue_valid, 0);
        cdb(9, 'h10); tick(); idle();
        chk("t2_valid", issue_valid, 1);
        chk("t2_s1",    issue_s1, 'h10);
        issue_ready = 1'b1; tick();
        chk("t2_empty", issue_valid, 0);

        // 3: fill, overflow dispatch ignored, drain in age order.
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(10 + k, k, 1, 0, 16 * k, 1, 0, k); tick();
        end
        chk("t3_full", rs_int_is_full, 1);
        disp(20, 9, 1, 0, 1, 1, 0, 1); tick(); idle();
        chk("t3_still_full", rs_int_is_full, 1);
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_order", issue_op, 10 + k);
            tick();
        end
        chk("t3_drained", issue_valid, 0);

        // 4: younger ready entry bypasses a waiting older one; compaction.
        disp(30, 1, 0, 2, 0, 1, 0, 1); tick();
        disp(31, 2, 1, 0, 3, 1, 0, 4); tick();
        chk("t4_first", issue_op, 31);
        disp(32, 3, 1, 0, 5, 1, 0, 6); tick(); idle();
        chk("t4_second", issue_op, 32);
        cdb(2, 'h55); tick(); idle();
        chk("t4_third", issue_op, 30);
        chk("t4_s1",    issue_s1, 'h55);
        tick();
        chk("t4_empty", issue_valid, 0);

        // 5: dispatch-time CDB bypass.
        issue_ready = 1'b0;
        disp(40, 5, 0, 6, 0, 1, 0, 1); cdb(6, 'hAB); tick(); idle();
        chk("t5_valid", issue_valid, 1);
        chk("t5_s1",    issue_s1, 'hAB);
        issue_ready = 1'b1; tick();

        // 6: flush dominates dispatch; then async reset mid-dispatch.
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(50 + k, k, 1, 0, k, 1, 0, k); tick();
        end
        signal_miss = 1'b1; tick(); idle();
        chk("t6_flush_valid", issue_valid, 0);
        chk("t6_flush_full",  rs_int_is_full, 0);
        disp(60, 1, 1, 0, 1, 1, 0, 2); tick();
        disp(61, 2, 1, 0, 3, 1, 0, 4); tick();
        disp(62, 3, 1, 0, 5, 1, 0, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", issue_valid, 0);
        chk("t6_rst_full",  rs_int_is_full, 0);
        chk("t6_rst_op",    issue_op, 0);
        chk("t6_rst_dest",  issue_dest, 0);
        chk("t6_rst_s2",    issue_s2, 0);
        tick(); idle();
        rst_n = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0)
                disp($urandom_range(0, 63), $urandom_range(0, 15),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
            else
                rs_int_we = 1'b0;
            if ($urandom_range(0, 1) == 1) cdb($urandom_range(0, 7), $urandom);
            else cdb_valid = 1'b0;
            issue_ready = ($urandom_range(0, 3) != 0);
            signal_miss = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
